// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: controller state encoding and default PC width.
package pipeline_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIR    = 2'd2
    } pipe_ctrl_state_e;

endpackage

// File: rtl/perf_cnt.sv
// Free-running event counter that wraps at 2^CNT_W.
// Exists only when PIPE_CTRL_PERF_EN is defined, since it is the only user.
`ifdef PIPE_CTRL_PERF_EN
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller for a 5-stage pipeline.
// PIPE_CTRL_PERF_EN adds stall/flush performance counters (stall_cnt_o, flush_cnt_o).
//
// state       | meaning
// ST_RUN      | normal flow; services redirect, load-use, fetch miss
// ST_MEM_WAIT | MEM access stalled; whole pipe frozen until dmem_ready_i
// ST_REDIR    | one-cycle replay of a redirect latched during a memory wait
module pipe_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = pipeline_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_use_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            imem_valid_i,
    input  logic            dmem_req_i,
    input  logic            dmem_ready_i,
    output logic            pc_en_o,
    output logic            ifid_en_o,
    output logic            idex_en_o,
    output logic            exmem_en_o,
    output logic            memwb_en_o,
    output logic            ifid_flush_o,
    output logic            idex_flush_o,
    output logic            memwb_flush_o,
    output logic            pc_sel_o,
    output logic [XLEN-1:0] pc_tgt_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    pipe_ctrl_state_e state, state_nxt;
    logic             pend_vld;
    logic [XLEN-1:0]  pend_pc;
    logic             mem_busy;
    logic             pend_set;
    logic             pend_clr;

    assign mem_busy = dmem_req_i & ~dmem_ready_i;

    // A redirect that cannot be taken this cycle is parked; the oldest one wins.
    assign pend_set = redirect_i & ~pend_vld & (mem_busy | (state == ST_MEM_WAIT));
    assign pend_clr = (state == ST_REDIR) & ~mem_busy;

    always_comb begin
        state_nxt     = state;
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        idex_en_o     = 1'b1;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        memwb_flush_o = 1'b0;
        pc_sel_o      = 1'b0;
        pc_tgt_o      = '0;
        if (!rst_n) begin
            state_nxt     = ST_RUN;
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_en_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            memwb_flush_o = 1'b1;
        end else if (mem_busy) begin
            state_nxt     = ST_MEM_WAIT;
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_en_o    = 1'b0;
            memwb_flush_o = 1'b1;
        end else begin
            case (state)
                ST_MEM_WAIT: begin
                    state_nxt = (pend_vld | redirect_i) ? ST_REDIR : ST_RUN;
                end
                ST_REDIR: begin
                    state_nxt    = ST_RUN;
                    pc_sel_o     = 1'b1;
                    pc_tgt_o     = pend_pc;
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                end
                default: begin
                    state_nxt = ST_RUN;
                    if (redirect_i) begin
                        pc_sel_o     = 1'b1;
                        pc_tgt_o     = redirect_pc_i;
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use_i) begin
                        pc_en_o      = 1'b0;
                        ifid_en_o    = 1'b0;
                        idex_flush_o = 1'b1;
                    end else if (!imem_valid_i) begin
                        pc_en_o      = 1'b0;
                        ifid_flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else begin
            state <= state_nxt;
            if (pend_clr) begin
                pend_vld <= 1'b0;
            end else if (pend_set) begin
                pend_vld <= 1'b1;
                pend_pc  <= redirect_pc_i;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_en_o & rst_n),
        .cnt   (stall_cnt_o)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_sel_o),
        .cnt   (flush_cnt_o)
    );
`endif

endmodule
